// File: rtl/ex_stage.sv
// rtl/ex_stage.sv - RV32 execute stage: forwarding, ALU, optional iterative divider (EX_STAGE_DIV_EN)
package ex_stage_pkg;
    localparam int EX_XLEN = 32;

    localparam logic [3:0] ALU_ADD   = 4'd0;
    localparam logic [3:0] ALU_SUB   = 4'd1;
    localparam logic [3:0] ALU_AND   = 4'd2;
    localparam logic [3:0] ALU_OR    = 4'd3;
    localparam logic [3:0] ALU_XOR   = 4'd4;
    localparam logic [3:0] ALU_SLT   = 4'd5;
    localparam logic [3:0] ALU_SLTU  = 4'd6;
    localparam logic [3:0] ALU_SLL   = 4'd7;
    localparam logic [3:0] ALU_SRL   = 4'd8;
    localparam logic [3:0] ALU_SRA   = 4'd9;
    localparam logic [3:0] ALU_PASSB = 4'd10;

    typedef struct packed {
        logic [EX_XLEN-1:0] RD1;
        logic [EX_XLEN-1:0] RD2;
        logic [4:0]         Rd;
        logic [4:0]         Rs1;
        logic [4:0]         Rs2;
        logic [2:0]         funct3;
        logic [3:0]         ALUControl;
        logic               ALUSrc;
        logic               DivOp;
        logic               RegWrite;
        logic               MemWrite;
        logic [1:0]         ResultSrc;
        logic [EX_XLEN-1:0] PC;
        logic [EX_XLEN-1:0] PCPlus4;
        logic [EX_XLEN-1:0] ImmExt;
    } idex_t;

    typedef struct packed {
        logic [EX_XLEN-1:0] ALUResult;
        logic [EX_XLEN-1:0] WriteData;
        logic [4:0]         Rd;
        logic [2:0]         funct3;
        logic               RegWrite;
        logic               MemWrite;
        logic [1:0]         ResultSrc;
        logic [EX_XLEN-1:0] PCPlus4;
    } exmem_t;
endpackage

module ex_stage
    import ex_stage_pkg::*;
#(
    parameter int XLEN       = EX_XLEN,
    parameter int DIV_CYCLES = XLEN
) (
    input  logic            clk,
    input  logic            reset,
    input  idex_t           inputs,
    input  logic            FlushE,
    input  logic [1:0]      ForwardAE,
    input  logic [1:0]      ForwardBE,
    input  logic [XLEN-1:0] ResultW,
    input  logic [XLEN-1:0] ALUResultM,
    output exmem_t          outputs,
    output logic            DivBusyE,
    output logic [4:0]      Rs1E,
    output logic [4:0]      Rs2E,
    output logic [4:0]      RdE
);
    localparam int SHW = $clog2(XLEN);

    logic [XLEN-1:0] fwd_a, fwd_b, src_a, src_b, alu_res, div_result;
    logic            div_busy, squash;
    logic            unused_pc;

    // operand forwarding: 01 takes writeback, 10 takes the memory-stage ALU result
    always_comb begin
        case (ForwardAE)
            2'b01:   fwd_a = ResultW;
            2'b10:   fwd_a = ALUResultM;
            default: fwd_a = inputs.RD1;
        endcase
        case (ForwardBE)
            2'b01:   fwd_b = ResultW;
            2'b10:   fwd_b = ALUResultM;
            default: fwd_b = inputs.RD2;
        endcase
    end

    assign src_a = fwd_a;
    assign src_b = inputs.ALUSrc ? inputs.ImmExt : fwd_b;

    // single-cycle integer ALU
    always_comb begin
        case (inputs.ALUControl)
            ALU_ADD:   alu_res = src_a + src_b;
            ALU_SUB:   alu_res = src_a - src_b;
            ALU_AND:   alu_res = src_a & src_b;
            ALU_OR:    alu_res = src_a | src_b;
            ALU_XOR:   alu_res = src_a ^ src_b;
            ALU_SLT:   alu_res = {{(XLEN-1){1'b0}}, $signed(src_a) < $signed(src_b)};
            ALU_SLTU:  alu_res = {{(XLEN-1){1'b0}}, src_a < src_b};
            ALU_SLL:   alu_res = src_a << src_b[SHW-1:0];
            ALU_SRL:   alu_res = src_a >> src_b[SHW-1:0];
            ALU_SRA:   alu_res = $signed(src_a) >>> src_b[SHW-1:0];
            ALU_PASSB: alu_res = src_b;
            default:   alu_res = '0;
        endcase
    end

`ifdef EX_STAGE_DIV_EN
    // funct3: bit1 selects remainder, bit0 selects unsigned
    localparam int CW = (DIV_CYCLES > 1) ? $clog2(DIV_CYCLES) : 1;
    typedef enum logic [1:0] {S_IDLE, S_DIV, S_DONE} state_t;

    state_t          state_q;
    logic [CW-1:0]   cnt_q;
    logic [XLEN-1:0] quot_q, rem_q, dvsr_q;
    logic            q_neg_q, r_neg_q, is_rem_q;

    logic            is_rem, is_uns, a_neg, b_neg, div_zero, div_ovf, start, qbit;
    logic [XLEN-1:0] a_abs, b_abs, rem_next, quot_next;
    logic [XLEN:0]   shifted, diff;

    assign is_rem   = inputs.funct3[1];
    assign is_uns   = inputs.funct3[0];
    assign a_neg    = !is_uns && src_a[XLEN-1];
    assign b_neg    = !is_uns && src_b[XLEN-1];
    assign a_abs    = a_neg ? -src_a : src_a;
    assign b_abs    = b_neg ? -src_b : src_b;
    assign div_zero = inputs.DivOp && (src_b == '0);
    assign div_ovf  = inputs.DivOp && !is_uns && (src_a == {1'b1, {(XLEN-1){1'b0}}}) && (src_b == '1);
    assign start    = inputs.DivOp && !div_zero && !div_ovf;

    // one restoring step: shift the next dividend bit into the partial remainder, subtract if it fits
    assign shifted   = {rem_q, quot_q[XLEN-1]};
    assign diff      = shifted - {1'b0, dvsr_q};
    assign qbit      = !diff[XLEN];
    assign rem_next  = qbit ? diff[XLEN-1:0] : shifted[XLEN-1:0];
    assign quot_next = {quot_q[XLEN-2:0], qbit};

    // divider FSM; a flush or reset abandons any divide in flight
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            quot_q   <= '0;
            rem_q    <= '0;
            dvsr_q   <= '0;
            q_neg_q  <= 1'b0;
            r_neg_q  <= 1'b0;
            is_rem_q <= 1'b0;
        end else if (FlushE) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                S_IDLE: if (start) begin
                    quot_q   <= a_abs;
                    rem_q    <= '0;
                    dvsr_q   <= b_abs;
                    q_neg_q  <= a_neg ^ b_neg;
                    r_neg_q  <= a_neg;
                    is_rem_q <= is_rem;
                    cnt_q    <= CW'(DIV_CYCLES - 1);
                    state_q  <= S_DIV;
                end
                S_DIV: begin
                    quot_q <= quot_next;
                    rem_q  <= rem_next;
                    if (cnt_q == '0) state_q <= S_DONE;
                    else             cnt_q   <= cnt_q - 1'b1;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // divide result and stall request; special cases resolve in IDLE without stalling
    always_comb begin
        div_result = '0;
        div_busy   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (div_zero)     div_result = is_rem ? src_a : '1;
                else if (div_ovf) div_result = is_rem ? '0 : src_a;
                else              div_busy   = inputs.DivOp;
            end
            S_DIV:  div_busy = 1'b1;
            S_DONE: div_result = is_rem_q ? (r_neg_q ? -rem_q : rem_q)
                                          : (q_neg_q ? -quot_q : quot_q);
            default: ;
        endcase
        if (reset || FlushE) div_busy = 1'b0;
    end
`else
    logic unused_div;
    assign unused_div = clk;
    assign div_result = '0;
    assign div_busy   = 1'b0;
`endif

    assign unused_pc = ^inputs.PC;
    assign squash    = div_busy || FlushE || reset;

    // memory-stage bundle; writes are suppressed while E is stalled or squashed
    always_comb begin
        outputs           = '0;
        outputs.ALUResult = inputs.DivOp ? div_result : alu_res;
        outputs.WriteData = fwd_b;
        outputs.Rd        = inputs.Rd;
        outputs.funct3    = inputs.funct3;
        outputs.RegWrite  = inputs.RegWrite && !squash;
        outputs.MemWrite  = inputs.MemWrite && !squash;
        outputs.ResultSrc = inputs.ResultSrc;
        outputs.PCPlus4   = inputs.PCPlus4;
    end

    assign DivBusyE = div_busy;
    assign Rs1E     = inputs.Rs1;
    assign Rs2E     = inputs.Rs2;
    assign RdE      = inputs.Rd;
endmodule

// File: doc/ex_stage.md
EX_STAGE -- requirements
Module: ex_stage

Interface
REQ-001 Parameter XLEN, default 32, datapath width.
REQ-002 Parameter DIV_CYCLES, default XLEN, number of divider iteration cycles (1 quotient bit per cycle).
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 reset  input  1  asynchronous, active-high.
REQ-005 inputs  input  idex_t  decoded E-stage instruction: operands, Rd, Rs1, Rs2, funct3, ALUControl, ALUSrc, DivOp, RegWrite, MemWrite, ResultSrc, PC, PCPlus4, ImmExt.
REQ-006 FlushE  input  1  squash E-stage instruction, abort divide.
REQ-007 ForwardAE, ForwardBE  input  2 each  00 register, 01 ResultW, 10 ALUResultM.
REQ-008 ResultW, ALUResultM  input  XLEN each  forwarded values.
REQ-009 outputs  output  exmem_t  fields consumed by the memory stage.
REQ-010 DivBusyE  output  1  divider occupying E; hazard unit stalls F/D/E.
REQ-011 Rs1E, Rs2E, RdE  output  5 each  to hazard unit.

Function
REQ-012 SrcA/SrcB SHALL be selected combinationally by ForwardAE/BE; SrcB SHALL be ImmExt when ALUSrc=1.
REQ-013 Non-divide ops SHALL produce outputs.ALUResult combinationally, zero added latency.
REQ-014 outputs.WriteData SHALL be the forwarded rs2 value; remaining exmem_t fields SHALL pass through from inputs.
REQ-015 Divider FSM states SHALL be IDLE, DIV, DONE.
REQ-016 IDLE: DivOp=1, divisor nonzero, no signed overflow -> latch |SrcA|, |SrcB|, sign flags, funct3; DivBusyE=1; go DIV with counter=DIV_CYCLES-1.
REQ-017 DIV: one restoring shift-subtract step per cycle; DivBusyE=1; at counter 0 go DONE.
REQ-018 DONE: DivBusyE=0; outputs.ALUResult SHALL be the sign-corrected quotient (DIV/DIVU) or remainder (REM/REMU); next state IDLE.
REQ-019 Divide latency: op entering E at cycle 0 SHALL present its result in cycle DIV_CYCLES+1; DivBusyE high cycles 0..DIV_CYCLES.
REQ-020 Sign rule: quotient negative iff operand signs differ (signed ops); remainder takes dividend sign.
REQ-021 Divide by zero SHALL complete in IDLE, DivBusyE=0: quotient all-ones, remainder = dividend.
REQ-022 Signed overflow (-2^(XLEN-1) / -1) SHALL complete in IDLE: quotient = dividend, remainder 0.
REQ-023 While DivBusyE=1, outputs.RegWrite and outputs.MemWrite SHALL be 0 (bubble to M).
REQ-024 FlushE=1 in any state SHALL force IDLE next cycle, DivBusyE=0 in that cycle, outputs.RegWrite/MemWrite=0.
REQ-025 DONE SHALL NOT re-trigger on the same instruction; a back-to-back divide starts from IDLE the following cycle.

Reset
REQ-026 reset SHALL force FSM to IDLE, counter 0, quotient/remainder/latched operands 0, DivBusyE=0, regardless of clk.
REQ-027 Reset asserted mid-divide SHALL discard the operation; no result SHALL be produced after release.

Configuration
REQ-028 Macro EX_STAGE_DIV_EN: defined -> divider and FSM present as above.
REQ-029 Undefined -> no divider state; DivBusyE tied 0; DivOp instructions SHALL yield ALUResult 0 with RegWrite passed through, single cycle.

Verification
REQ-030 ADD SrcA=5, SrcB=7, ForwardAE=10 with ALUResultM=3 -> ALUResult=10 same cycle, DivBusyE=0.
REQ-031 DIV -20 / 3 -> DivBusyE high 33 cycles, result -6 in cycle 33; REM same operands -> -2.
REQ-032 DIVU 100 / 0 -> ALUResult=0xFFFFFFFF same cycle; REMU -> 100; DivBusyE never high.
REQ-033 DIV 0x80000000 / -1 -> 0x80000000, REM -> 0, single cycle.
REQ-034 DIVU 1000/7 started, FlushE at cycle 10 -> IDLE at cycle 11, DivBusyE low, no RegWrite issued.
REQ-035 Reset pulsed at cycle 5 of a divide -> DivBusyE low immediately; next DIVU 9/2 -> 4 at cycle 33.
